// File: rtl/calc_ctrl.sv
// calc_ctrl: command sequencer and accumulator for the calculator's 16-bit ALU.
//
// Accepts one command at a time (cmd_valid/cmd_ready). Drives the external
// combinational ALU for exactly one cycle (EXEC), captures its result into the
// accumulator, and returns the result on res_valid/res_ready.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op (4b) opcode, cmd_data (16b) operand
//   alu_sel/alu_a/alu_b  to the ALU; nonzero only during EXEC
//   alu_y                ALU result (truncated to 16 bits)
//   res_valid/res_ready  result handshake; res_data (16b) held stable while pending
//   acc                  accumulator, for the display
//   flag_zero/flag_carry status of the last ALU result
//   err                  sticky illegal-opcode flag, cleared by CLEAR

module calc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic [3:0]  alu_sel,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [15:0] acc,
    output logic        flag_zero,
    output logic        flag_carry,
    output logic        err
);

    localparam logic [3:0] OpAdd    = 4'd8;
    localparam logic [3:0] OpSub    = 4'd9;
    localparam logic [3:0] OpMul    = 4'd10;
    localparam logic [3:0] OpLoad   = 4'd11;
    localparam logic [3:0] OpClear  = 4'd12;
    localparam logic [3:0] OpRepeat = 4'd13;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t      state;
    logic [3:0]  op_q;      // latched opcode
    logic [15:0] data_q;    // latched operand
    logic        use_alu_q; // EXEC takes its result from the ALU
    logic        last_vld_q;
    logic [3:0]  last_op_q;
    logic [15:0] last_b_q;

    // The ALU only returns 16 bits, so carry/borrow are rebuilt from its inputs.
    logic [16:0] sum_wide;
    logic [31:0] prod_wide;
    logic        carry;

    assign sum_wide  = {1'b0, alu_a} + {1'b0, alu_b};
    assign prod_wide = {16'd0, alu_a} * {16'd0, alu_b};

    always_comb begin
        carry = 1'b0;
        case (alu_sel)
            OpAdd:   carry = (sum_wide > 17'h0FFFF);
            OpSub:   carry = (alu_a < alu_b);
            OpMul:   carry = (prod_wide > 32'h0000FFFF);
            default: carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            cmd_ready  <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= 16'd0;
            acc        <= 16'd0;
            alu_sel    <= 4'd0;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            err        <= 1'b0;
            op_q       <= 4'd0;
            data_q     <= 16'd0;
            use_alu_q  <= 1'b0;
            last_vld_q <= 1'b0;
            last_op_q  <= 4'd0;
            last_b_q   <= 16'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        data_q    <= cmd_data;
                        cmd_ready <= 1'b0;
                        state     <= StExec;
                        // ALU inputs are registered so they are valid for all of EXEC.
                        if (cmd_op <= OpMul) begin
                            alu_sel   <= cmd_op;
                            alu_a     <= acc;
                            alu_b     <= cmd_data;
                            use_alu_q <= 1'b1;
                        end else if (cmd_op == OpRepeat && last_vld_q) begin
                            alu_sel   <= last_op_q;
                            alu_a     <= acc;
                            alu_b     <= last_b_q;
                            use_alu_q <= 1'b1;
                        end else begin
                            use_alu_q <= 1'b0;
                        end
                    end
                end

                StExec: begin
                    state     <= StResp;
                    res_valid <= 1'b1;
                    alu_sel   <= 4'd0;
                    alu_a     <= 16'd0;
                    alu_b     <= 16'd0;
                    if (use_alu_q) begin
                        acc        <= alu_y;
                        res_data   <= alu_y;
                        flag_zero  <= (alu_y == 16'd0);
                        flag_carry <= carry;
                        // Op 0 is never recorded as a repeatable op.
                        if (alu_sel != 4'd0) begin
                            last_vld_q <= 1'b1;
                            last_op_q  <= alu_sel;
                            last_b_q   <= alu_b;
                        end
                    end else begin
                        case (op_q)
                            OpLoad: begin
                                acc      <= data_q;
                                res_data <= data_q;
                            end
                            OpClear: begin
                                acc        <= 16'd0;
                                res_data   <= 16'd0;
                                err        <= 1'b0;
                                flag_zero  <= 1'b0;
                                flag_carry <= 1'b0;
                                last_vld_q <= 1'b0;
                                last_op_q  <= 4'd0;
                                last_b_q   <= 16'd0;
                            end
                            4'd14, 4'd15: begin
                                err      <= 1'b1;
                                res_data <= acc;
                            end
                            // REPEAT with nothing recorded: report acc unchanged.
                            default: res_data <= acc;
                        endcase
                    end
                end

                StResp: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end

                default: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
